aes_subbytes_pipe: RTL and testbench

Pipelined, multi-lane AES SubBytes/InvSubBytes engine with valid/ready flow control. It replaces the flat combinational S-box timing cones in the AES datapath with a registered block. It is parametrised in lane count and pipeline depth, and it adds a per-transaction direction mode. It sits between the AddRoundKey and ShiftRows stages of the round datapath.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_sbox_lane.sv | 20 ++
 rtl/aes_subbytes_pipe.sv | 116 +++++++++++
 tb/tb_aes_subbytes_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte-level arithmetic: GF(2^8) inverse and the forward/inverse affine maps.
package aes_pkg;

    typedef logic [7:0] lane_byte_t;

    localparam lane_byte_t AES_POLY     = 8'h1B;
    localparam lane_byte_t AFFINE_C     = 8'h63;
    localparam lane_byte_t INV_AFFINE_C = 8'h05;

    function automatic lane_byte_t rotl8(lane_byte_t b, int unsigned n);
        lane_byte_t r;
        r = b;
        for (int unsigned i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic lane_byte_t gf_mul8(lane_byte_t a, lane_byte_t b);
        lane_byte_t p;
        lane_byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ AES_POLY) : (x << 1);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); 0 maps to 0 for free.
    function automatic lane_byte_t gf_inv8(lane_byte_t a);
        lane_byte_t sq;
        lane_byte_t acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul8(sq, sq);
            acc = gf_mul8(acc, sq);
        end
        return acc;
    endfunction

    function automatic lane_byte_t affine_fwd(lane_byte_t b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ AFFINE_C;
    endfunction

    function automatic lane_byte_t affine_inv(lane_byte_t b);
        return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane of the S-box, cut into three combinational pieces so the top can place registers between them.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  lane_byte_t a_in,
    input  logic       mode_a,
    output lane_byte_t a_out,
    input  lane_byte_t b_in,
    output lane_byte_t b_out,
    input  lane_byte_t c_in,
    input  logic       mode_c,
    output lane_byte_t c_out
);

    // Forward: identity -> inverse -> affine. Inverse: inverse affine -> inverse -> identity.
    assign a_out = mode_a ? affine_inv(a_in) : a_in;
    assign b_out = gf_inv8(b_in);
    assign c_out = mode_c ? c_in : affine_fwd(c_in);

endmodule

// File: rtl/aes_subbytes_pipe.sv
// Multi-lane pipelined SubBytes/InvSubBytes with valid/ready; mode rides alongside the data in every slot.
module aes_subbytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int STAGES      = 2,
    parameter int SUPPORT_INV = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mode,
    input  logic [8*LANES-1:0]          in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [8*LANES-1:0]          out_data,
    output logic                        out_mode,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    typedef struct packed {
        logic                   mode;
        lane_byte_t [LANES-1:0] data;
    } slot_t;

    slot_t [STAGES-1:0] slot_q;
    slot_t [STAGES-1:0] d_in;
    logic  [STAGES-1:0] vld_pipe, vld_nxt, adv, load, ld_data;
    logic  [OCC_W-1:0]  occ_q, occ_nxt;

    lane_byte_t [LANES-1:0] a_in, a_out, b_in, b_out, c_in, c_out;
    logic eff_mode, mode_c;

    // With the inverse path disabled the mode is forced low and the inverse logic folds away.
    assign eff_mode = (SUPPORT_INV != 0) && in_mode;
    assign a_in     = in_data;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        aes_sbox_lane u_lane (
            .a_in   (a_in[k]),
            .mode_a (eff_mode),
            .a_out  (a_out[k]),
            .b_in   (b_in[k]),
            .b_out  (b_out[k]),
            .c_in   (c_in[k]),
            .mode_c (mode_c),
            .c_out  (c_out[k])
        );
    end

    if (STAGES == 1) begin : g_split1
        always_comb begin
            b_in    = a_out;
            c_in    = b_out;
            mode_c  = eff_mode;
            d_in[0] = {eff_mode, c_out};
        end
    end else if (STAGES == 2) begin : g_split2
        always_comb begin
            b_in    = a_out;
            d_in[0] = {eff_mode, b_out};
            c_in    = slot_q[0].data;
            mode_c  = slot_q[0].mode;
            d_in[1] = {slot_q[0].mode, c_out};
        end
    end else begin : g_split3
        always_comb begin
            d_in[0] = {eff_mode, a_out};
            b_in    = slot_q[0].data;
            d_in[1] = {slot_q[0].mode, b_out};
            c_in    = slot_q[1].data;
            mode_c  = slot_q[1].mode;
            d_in[2] = {slot_q[1].mode, c_out};
        end
    end

    // Advance chain runs back from out_ready; it is the only input-to-output combinational path.
    always_comb begin
        adv[STAGES-1] = out_ready;
        for (int i = STAGES - 2; i >= 0; i--) adv[i] = !vld_pipe[i+1] || adv[i+1];
        load       = ~vld_pipe | adv;
        vld_nxt    = vld_pipe;
        ld_data    = '0;
        if (load[0]) vld_nxt[0] = in_valid;
        ld_data[0] = load[0] && in_valid;
        for (int i = 1; i < STAGES; i++) begin
            if (load[i]) vld_nxt[i] = vld_pipe[i-1];
            ld_data[i] = load[i] && vld_pipe[i-1];
        end
        occ_nxt = '0;
        for (int i = 0; i < STAGES; i++) occ_nxt = occ_nxt + OCC_W'(vld_nxt[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            occ_q    <= '0;
            slot_q   <= '0;
        end else begin
            vld_pipe <= vld_nxt;
            occ_q    <= occ_nxt;
            for (int i = 0; i < STAGES; i++)
                if (ld_data[i]) slot_q[i] <= d_in[i];
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_pipe[STAGES-1];
    assign out_data  = slot_q[STAGES-1].data;
    assign out_mode  = slot_q[STAGES-1].mode;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Randomised and directed checks of aes_subbytes_pipe against a table-driven S-box model.
module tb_aes_subbytes_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;

    logic        n_in_valid, n_in_ready, n_in_mode, n_out_valid, n_out_ready, n_out_mode;
    logic [15:0] n_in_data, n_out_data;
    logic [1:0]  n_occupancy;

    always #5 clk = ~clk;

    aes_subbytes_pipe #(.LANES(4), .STAGES(2), .SUPPORT_INV(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .occupancy(occupancy)
    );

    aes_subbytes_pipe #(.LANES(2), .STAGES(3), .SUPPORT_INV(0)) dut_fwd (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_mode(n_in_mode),
        .in_data(n_in_data), .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .out_mode(n_out_mode), .occupancy(n_occupancy)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  sbox  [256];
    logic [7:0]  isbox [256];
    logic [32:0] exp_q [$];
    logic [31:0] rx_q  [$];
    int          out_cyc [$];
    int          n_out = 0;
    int          cyc = 0;
    bit          hold = 0;
    logic [32:0] hold_val;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_mul(int a, int b);
        int p, x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if ((b >> i) & 1) p = p ^ x;
            x = x << 1;
            if (x & 256) x = x ^ 'h11B;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_aff(logic [7:0] b);
        logic [7:0] c, s;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        return s;
    endfunction

    task automatic build_tables();
        int inv;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            if (x != 0)
                for (int y = 1; y < 256; y++) if (m_mul(x, y) == 1) inv = y;
            sbox[x] = m_aff(inv[7:0]);
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = x[7:0];
    endtask

    function automatic logic [32:0] model(logic m, logic [31:0] d);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = m ? isbox[d[8*k +: 8]] : sbox[d[8*k +: 8]];
        return {m, r};
    endfunction

    // Scoreboard and hold-stability monitor; handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_word", {out_mode, out_data}, hold_val);
            end
            hold     = out_valid && !out_ready;
            hold_val = {out_mode, out_data};
            if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_data));
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                rx_q.push_back(out_data);
                n_out++;
                if (exp_q.size() == 0) chk("sb_underflow", out_valid, 0);
                else chk("sb_word", {out_mode, out_data}, exp_q.pop_front());
            end
        end
    end

    task automatic drive_word(input logic m, input logic [31:0] d, input bit rnd);
        int t = 0;
        in_valid = 1;
        in_mode  = m;
        in_data  = d;
        forever begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            t++;
            if (t > 200) begin
                chk("accept_timeout", in_ready, 1);
                break;
            end
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        logic [31:0] fwd_res [256];
        logic [31:0] w;
        int          base;
        rst = 1; in_valid = 0; in_mode = 0; in_data = '0; out_ready = 1;
        n_in_valid = 0; n_in_mode = 0; n_in_data = '0; n_out_ready = 1;
        build_tables();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_n_out_valid", n_out_valid, 0);
        rst = 0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed forward and inverse words, latency two cycles.
        in_valid = 1; in_mode = 0; in_data = 32'h00010253;
        @(posedge clk); #1; in_valid = 0;
        @(posedge clk); #1;
        chk("fwd_valid", out_valid, 1);
        chk("fwd_data", out_data, 32'h637C77ED);
        chk("fwd_mode", out_mode, 0);
        in_valid = 1; in_mode = 1; in_data = 32'h637C77ED;
        @(posedge clk); #1; in_valid = 0;
        @(posedge clk); #1;
        chk("inv_valid", out_valid, 1);
        chk("inv_data", out_data, 32'h00010253);
        chk("inv_mode", out_mode, 1);
        drain();

        // All 256 bytes forward, then the results back through the inverse path.
        rx_q.delete();
        for (int v = 0; v < 256; v++) drive_word(0, {4{v[7:0]}}, 0);
        drain();
        chk("sweep_fwd_count", rx_q.size(), 256);
        if (rx_q.size() == 256) begin
            for (int v = 0; v < 256; v++) fwd_res[v] = rx_q[v];
            rx_q.delete();
            for (int v = 0; v < 256; v++) drive_word(1, fwd_res[v], 0);
            drain();
            chk("sweep_inv_count", rx_q.size(), 256);
            if (rx_q.size() == 256)
                for (int v = 0; v < 256; v++) chk("roundtrip", rx_q[v], {4{v[7:0]}});
        end

        // Ten back-to-back words: no input stall, no output gap.
        out_cyc.delete();
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_mode = i[0]; in_data = $urandom;
            #1;
            chk("stream_in_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 0;
        drain();
        chk("stream_count", out_cyc.size(), 10);
        if (out_cyc.size() == 10) chk("stream_gapless", out_cyc[9] - out_cyc[0], 9);

        // Backpressure: two words fill the pipe, third is held upstream.
        out_ready = 0;
        w = $urandom;
        drive_word(0, w, 0);
        drive_word(1, $urandom, 0);
        chk("stall_occ_full", occupancy, 2);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_head", {out_mode, out_data}, model(0, w));
        in_valid = 1; in_mode = 0; in_data = $urandom;
        #1;
        chk("stall_in_ready", in_ready, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_hold_word", {out_mode, out_data}, model(0, w));
            chk("stall_hold_occ", occupancy, 2);
            chk("stall_hold_ready", in_ready, 0);
        end
        out_ready = 1;
        #1;
        chk("release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        chk("release_occ", occupancy, 2);
        drain();

        // Reset with a full pipe drops everything at once.
        out_ready = 0;
        drive_word(0, $urandom, 0);
        drive_word(1, $urandom, 0);
        chk("rst_mid_pre_occ", occupancy, 2);
        rst = 1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_occ", occupancy, 0);
        @(posedge clk); #1;
        rst = 0; out_ready = 1;
        base = n_out;
        repeat (6) begin
            @(posedge clk); #1;
            chk("rst_mid_no_stale", out_valid, 0);
        end
        chk("rst_mid_no_output", n_out - base, 0);

        // Random traffic with random backpressure and mixed modes.
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            drive_word($urandom_range(0, 1), $urandom, 1);
        end
        drain();

        // Forward-only, three-stage, two-lane build ignores in_mode.
        n_in_valid = 1; n_in_mode = 1; n_in_data = 16'h0053;
        #1;
        chk("fo_in_ready", n_in_ready, 1);
        @(posedge clk); #1;
        n_in_valid = 0;
        chk("fo_occ", n_occupancy, 1);
        @(posedge clk); #1;
        chk("fo_not_early", n_out_valid, 0);
        @(posedge clk); #1;
        chk("fo_valid", n_out_valid, 1);
        chk("fo_data", n_out_data, 16'h63ED);
        chk("fo_mode", n_out_mode, 0);
        @(posedge clk); #1;
        chk("fo_drained", n_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
